// File: rtl/mux_pkg.sv
// mux_pkg: shared FSM state type and index helpers for mux_rr_stream
package mux_pkg;
  typedef enum logic [1:0] {EMPTY, FULL, LOCKED} state_t;
  function automatic int chw(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int onehot_to_idx(logic [31:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant searching upward from ptr+1, with optional hold on lock_idx
module rr_arbiter import mux_pkg::*; #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]        req,
  input  logic [chw(N_CH)-1:0]   ptr,
  input  logic                   lock_en,
  input  logic [chw(N_CH)-1:0]   lock_idx,
  output logic [N_CH-1:0]        grant
);
  localparam int CHW = chw(N_CH);
  logic [CHW-1:0] j;
  // descending scan so the nearest requester after ptr is the last one written
  always_comb begin
    grant = '0;
    j = '0;
    if (lock_en) grant[lock_idx] = req[lock_idx];
    else for (int k = N_CH; k >= 1; k--) begin
      j = CHW'((int'(ptr) + k) % N_CH);
      if (req[j]) grant = N_CH'(1) << j;
    end
  end
endmodule

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-channel round-robin stream mux with one registered output stage.
// Optional packet lock (in_last/out_last, LOCKED state) enabled by MUX_RR_LAST_LOCK_EN.
module mux_rr_stream import mux_pkg::*; #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic [N_CH-1:0]         ch_mask,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [chw(N_CH)-1:0]    out_ch
`ifdef MUX_RR_LAST_LOCK_EN
  ,
  input  logic [N_CH-1:0]         in_last,
  output logic                    out_last
`endif
);
  localparam int CHW = chw(N_CH);
  state_t state, state_nx;
  logic [CHW-1:0] ptr, gidx;
  logic [N_CH-1:0] req, grant;
  logic load_en, xfer, locked, xfer_full;
`ifdef MUX_RR_LAST_LOCK_EN
  assign locked = state == LOCKED;
  assign xfer_full = in_last[gidx];
`else
  assign locked = 1'b0;
  assign xfer_full = 1'b1;
`endif
  // nothing is accepted while reset is asserted
  assign load_en = ~rst & (~out_valid | out_ready);
  assign req = locked ? in_valid : in_valid & ch_mask;
  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req(req), .ptr(ptr), .lock_en(locked), .lock_idx(ptr), .grant(grant)
  );
  assign in_ready = grant & {N_CH{load_en}};
  assign xfer = |in_ready;
  assign gidx = CHW'(onehot_to_idx(32'(grant)));
  always_comb begin
    state_nx = xfer ? (xfer_full ? FULL : LOCKED)
             : locked ? LOCKED
             : (out_valid & ~out_ready) ? FULL : EMPTY;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= CHW'(N_CH - 1);
`ifdef MUX_RR_LAST_LOCK_EN
      out_last <= 1'b0;
`endif
    end else begin
      if (load_en) out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[gidx*WIDTH +: WIDTH];
        out_ch <= gidx;
        ptr <= gidx;
`ifdef MUX_RR_LAST_LOCK_EN
        out_last <= in_last[gidx];
`endif
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_stream.sv
// tb_mux_rr_stream: table-driven directed check of mux_rr_stream (N_CH=4, WIDTH=8)
module tb_mux_rr_stream;
  logic        clk, rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready, ch_mask;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic [1:0]  out_ch;
  int n_vec = 0, n_err = 0;

  mux_rr_stream #(.N_CH(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ch_mask(ch_mask), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v, m;
    logic        r;
    logic [31:0] d;
    logic [3:0]  er;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  ec;
  } vec_t;
  vec_t tv[$];

  localparam logic [31:0] D = 32'h13121110;
  localparam logic [31:0] B = 32'h13A51110;

  function automatic void add(logic [3:0] v, m, logic r, logic [31:0] d,
                              logic [3:0] er, logic ev, logic [7:0] ed, logic [1:0] ec);
    tv.push_back('{v, m, r, d, er, ev, ed, ec});
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  initial begin
    // fairness rotation from reset pointer
    add(4'hF, 4'hF, 1, D, 4'b0001, 1, 8'h10, 0);
    add(4'hF, 4'hF, 1, D, 4'b0010, 1, 8'h11, 1);
    add(4'hF, 4'hF, 1, D, 4'b0100, 1, 8'h12, 2);
    add(4'hF, 4'hF, 1, D, 4'b1000, 1, 8'h13, 3);
    add(4'hF, 4'hF, 1, D, 4'b0001, 1, 8'h10, 0);
    add(4'h0, 4'hF, 1, D, 4'b0000, 0, 8'h10, 0);
    // backpressure on channel 2
    add(4'h4, 4'hF, 0, B, 4'b0100, 1, 8'hA5, 2);
    add(4'h4, 4'hF, 0, B, 4'b0000, 1, 8'hA5, 2);
    add(4'h4, 4'hF, 0, B, 4'b0000, 1, 8'hA5, 2);
    add(4'h4, 4'hF, 0, B, 4'b0000, 1, 8'hA5, 2);
    add(4'h0, 4'hF, 1, B, 4'b0000, 0, 8'hA5, 2);
    // masked channel 3 never served
    add(4'hA, 4'h7, 1, D, 4'b0010, 1, 8'h11, 1);
    add(4'hA, 4'h7, 1, D, 4'b0010, 1, 8'h11, 1);
    add(4'h0, 4'hF, 1, D, 4'b0000, 0, 8'h11, 1);
    // single beat drain, pointer left at 0
    add(4'h1, 4'hF, 1, D, 4'b0001, 1, 8'h10, 0);
    add(4'h0, 4'hF, 1, D, 4'b0000, 0, 8'h10, 0);
    add(4'h3, 4'hF, 1, D, 4'b0010, 1, 8'h11, 1);
    // all masked: no grant, output drains
    add(4'hF, 4'h0, 1, D, 4'b0000, 0, 8'h11, 1);

    rst = 1'b1; in_data = D; in_valid = 4'hF; ch_mask = 4'hF; out_ready = 1'b1;
    #1;
    chk("reset out_valid", -1, 32'(out_valid), 0);
    chk("reset out_data", -1, 32'(out_data), 0);
    chk("reset out_ch", -1, 32'(out_ch), 0);
    chk("reset in_ready", -1, 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    foreach (tv[i]) begin
      in_valid = tv[i].v; ch_mask = tv[i].m; out_ready = tv[i].r; in_data = tv[i].d;
      #1;
      chk("in_ready", i, 32'(in_ready), 32'(tv[i].er));
      @(posedge clk);
      #1;
      chk("out_valid", i, 32'(out_valid), 32'(tv[i].ev));
      chk("out_data", i, 32'(out_data), 32'(tv[i].ed));
      chk("out_ch", i, 32'(out_ch), 32'(tv[i].ec));
      @(negedge clk);
    end

    // asynchronous reset while a beat is held
    in_valid = 4'hF; ch_mask = 4'hF; out_ready = 1'b0; in_data = D;
    @(posedge clk);
    #1;
    chk("pre-reset out_valid", -2, 32'(out_valid), 1);
    chk("pre-reset out_ch", -2, 32'(out_ch), 2);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", -2, 32'(out_valid), 0);
    chk("async rst out_ch", -2, 32'(out_ch), 0);
    chk("async rst out_data", -2, 32'(out_data), 0);
    chk("async rst in_ready", -2, 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("post-reset in_ready", -3, 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk("post-reset out_valid", -3, 32'(out_valid), 1);
    chk("post-reset out_ch", -3, 32'(out_ch), 0);
    chk("post-reset out_data", -3, 32'(out_data), 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
